// File: rtl/contra_sprite_pkg.sv
// Shared types and constants for the Contra sprite engines.
// Also holds the boulder texel function that defines the boulder tile ROM contents.
package contra_sprite_pkg;

    localparam int TILE_W   = 32;
    localparam int TILE_H   = 32;
    localparam int ANIM_FR  = 4;
    localparam int GROUND_Y = 416;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int ROM_AW   = 12;  // {anim_fr[1:0], ty[4:0], tx[4:0]}

    typedef logic [2:0] pix_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FALL = 2'd1,
        ST_ROLL = 2'd2
    } boulder_state_t;

    // Round boulder of radius 16 with diagonal shading bands.
    // The bands shift by one per animation frame, which makes the boulder appear to roll.
    function automatic pix_idx_t boulder_texel(input logic [1:0] fr, input logic [4:0] ty,
                                               input logic [4:0] tx);
        logic signed [12:0] dx;
        logic signed [12:0] dy;
        logic signed [12:0] r2;
        logic [1:0]         band;
        dx   = $signed({8'd0, tx}) - 13'sd16;
        dy   = $signed({8'd0, ty}) - 13'sd16;
        r2   = dx * dx + dy * dy;
        band = tx[4:3] + ty[4:3] + fr;
        if (r2 < 13'sd256) return 3'd4 - {1'b0, band};
        return 3'd0;
    endfunction

endpackage

// File: rtl/contra_boulder_sprite_engine_if.sv
// Scan, control and pixel signals of the boulder sprite engine, plus state/position debug taps.
interface contra_boulder_sprite_engine_if;
    import contra_sprite_pkg::*;

    // frame_start and spawn are single-cycle pulses sampled on the clock edge; there is no backpressure.
    // pix_index/pix_hit describe the DrawX/DrawY presented two clocks earlier.
    logic               frame_start;
    logic               spawn;
    logic [9:0]         spawn_x;
    logic [9:0]         spawn_y;
    logic [9:0]         DrawX;
    logic [9:0]         DrawY;
    logic               blank;
    pix_idx_t           pix_index;
    logic               pix_hit;
    logic               active;
    boulder_state_t     dbg_state;
    logic signed [10:0] dbg_pos_x;
    logic [9:0]         dbg_pos_y;
    logic signed [4:0]  dbg_vy;

    modport master (
        output frame_start, spawn, spawn_x, spawn_y, DrawX, DrawY, blank,
        input  pix_index, pix_hit, active, dbg_state, dbg_pos_x, dbg_pos_y, dbg_vy
    );

    modport slave (
        input  frame_start, spawn, spawn_x, spawn_y, DrawX, DrawY, blank,
        output pix_index, pix_hit, active, dbg_state, dbg_pos_x, dbg_pos_y, dbg_vy
    );

endinterface

// File: rtl/contra_boulder_rom.sv
// Boulder tile ROM: ANIM_FR x TILE_H x TILE_W words of 3 bits, synchronous read with 1-cycle latency.
module contra_boulder_rom
    import contra_sprite_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ROM_AW-1:0] addr,
    output pix_idx_t          q
);

    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= boulder_texel(addr[11:10], addr[9:5], addr[4:0]);
    end

endmodule

// File: rtl/contra_boulder_sprite_engine.sv
// Rolling-boulder hazard: per-frame motion FSM (IDLE/FALL/ROLL) and a 2-stage per-pixel lookup
// that produces the palette index and opaque-hit flag.
module contra_boulder_sprite_engine
    import contra_sprite_pkg::*;
#(
    parameter int       ANIM_DIV   = 6,
    parameter int       ROLL_DX    = 2,
    parameter int       GRAV       = 1,
    parameter int       MAX_VY     = 8,
    parameter pix_idx_t TRANSP_IDX = 3'd0
)(
    input logic                          vga_clk,
    input logic                          reset,
    contra_boulder_sprite_engine_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FALL = 2'd1;
    localparam logic [1:0] S_ROLL = 2'd2;

    localparam int                 DIV_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(ANIM_DIV - 1);
    localparam logic signed [10:0] X_EXIT   = 11'(-TILE_W);
    localparam logic signed [10:0] X_STEP   = 11'(ROLL_DX);
    localparam logic signed [6:0]  VY_MAX   = 7'(MAX_VY);
    localparam logic signed [6:0]  VY_GRAV  = 7'(GRAV);
    localparam logic signed [11:0] Y_FLOOR  = 12'(GROUND_Y - TILE_H);
    localparam logic signed [11:0] TW       = 12'(TILE_W);
    localparam logic signed [11:0] TH       = 12'(TILE_H);

    logic [1:0]         state;
    logic signed [10:0] pos_x;
    logic [9:0]         pos_y;
    logic signed [4:0]  vy;
    logic [DIV_W-1:0]   anim_div;
    logic [1:0]         anim_fr;
    logic               active;

    logic signed [10:0] x_next;
    logic signed [6:0]  vy_sum;
    logic signed [6:0]  vy_fall7;
    logic signed [4:0]  vy_fall;
    logic signed [4:0]  vy_bounce;
    logic signed [11:0] y_sum;
    logic               grounded;
    logic               settle;
    logic               leave;

    assign active = (state != S_IDLE);

    always_comb begin
        x_next    = pos_x - X_STEP;
        leave     = (x_next <= X_EXIT);
        vy_sum    = $signed({{2{vy[4]}}, vy}) + VY_GRAV;
        vy_fall7  = (vy_sum > VY_MAX) ? VY_MAX : vy_sum;
        vy_fall   = vy_fall7[4:0];
        y_sum     = $signed({2'b00, pos_y}) + $signed({{7{vy_fall[4]}}, vy_fall});
        grounded  = (y_sum >= Y_FLOOR);
        vy_bounce = -(vy_fall >>> 1);
        settle    = (vy_bounce >= -5'sd1) && (vy_bounce <= 5'sd1);
    end

    // spawn takes priority over frame_start, so a spawn frame applies no motion.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state    <= S_IDLE;
            pos_x    <= '0;
            pos_y    <= '0;
            vy       <= '0;
            anim_div <= '0;
            anim_fr  <= '0;
        end else if (bus.spawn) begin
            state    <= S_FALL;
            pos_x    <= $signed({1'b0, bus.spawn_x});
            pos_y    <= bus.spawn_y;
            vy       <= '0;
            anim_div <= '0;
            anim_fr  <= '0;
        end else if (bus.frame_start && active) begin
            pos_x <= x_next;
            if (state == S_FALL) begin
                if (grounded) begin
                    pos_y <= Y_FLOOR[9:0];
                    vy    <= settle ? 5'sd0 : vy_bounce;
                end else begin
                    pos_y <= y_sum[11] ? 10'd0 : y_sum[9:0];
                    vy    <= vy_fall;
                end
            end
            if (leave)                                         state <= S_IDLE;
            else if (state == S_FALL && grounded && settle)    state <= S_ROLL;
            if (anim_div == DIV_LAST) begin
                anim_div <= '0;
                anim_fr  <= anim_fr + 2'd1;
            end else begin
                anim_div <= anim_div + DIV_W'(1);
            end
        end
    end

    // Stage 0: tile-relative coordinates of the current scan position.
    logic signed [11:0] tx;
    logic signed [11:0] ty;
    logic               in_box;
    logic [ROM_AW-1:0]  rom_addr;
    pix_idx_t           rom_q;
    logic               in_box_d;
    logic               blank_d;

    always_comb begin
        tx       = $signed({2'b00, bus.DrawX}) - $signed({pos_x[10], pos_x});
        ty       = $signed({2'b00, bus.DrawY}) - $signed({2'b00, pos_y});
        in_box   = active && (tx >= 12'sd0) && (tx < TW) && (ty >= 12'sd0) && (ty < TH);
        rom_addr = {anim_fr, ty[4:0], tx[4:0]};
    end

    contra_boulder_rom u_rom (
        .clk  (vga_clk),
        .rst  (reset),
        .addr (rom_addr),
        .q    (rom_q)
    );

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            in_box_d      <= 1'b0;
            blank_d       <= 1'b0;
            bus.pix_index <= '0;
            bus.pix_hit   <= 1'b0;
        end else begin
            in_box_d      <= in_box;
            blank_d       <= bus.blank;
            bus.pix_index <= in_box_d ? rom_q : TRANSP_IDX;
            bus.pix_hit   <= in_box_d && blank_d && (rom_q != TRANSP_IDX);
        end
    end

    assign bus.active    = active;
    assign bus.dbg_state = boulder_state_t'(state);
    assign bus.dbg_pos_x = pos_x;
    assign bus.dbg_pos_y = pos_y;
    assign bus.dbg_vy    = vy;

endmodule
